// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_I = 2'd1,
        ACC_D = 2'd2,
        ERR_D = 2'd3
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam logic [1:0] BA_BYTE = 2'b00;
    localparam logic [1:0] BA_HALF = 2'b01;
    localparam logic [1:0] BA_WORD = 2'b10;

    localparam int unsigned BE_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and memory-side bus of the arbiter, with arbiter (slave)
// and environment (master) views.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_byte;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              d_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_byte, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready, d_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_byte, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready, d_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-enable generation, store-data lane replication and misalignment detection
// for data-port accesses.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]      d_byte,
    input  logic [1:0]      addr,
    input  logic [31:0]     d_wdata,
    output logic [BE_W-1:0] be_c,
    output logic [31:0]     wdata_c,
    output logic            misalign_c
);

    always_comb begin
        be_c       = '0;
        wdata_c    = '0;
        misalign_c = 1'b0;
        case (d_byte)
            BA_BYTE: begin
                be_c    = 4'b0001 << addr;
                wdata_c = {4{d_wdata[7:0]}};
            end
            BA_HALF: begin
                be_c       = 4'b0011 << {addr[1], 1'b0};
                wdata_c    = {2{d_wdata[15:0]}};
                misalign_c = addr[0];
            end
            default: begin
                be_c       = 4'b1111;
                wdata_c    = d_wdata;
                misalign_c = (addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one fixed-latency single-port memory,
// alternating grants when both ports contend.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
)(
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned     CNT_W     = $clog2(MEM_LAT + 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t            state, state_n;
    grant_t            last_grant, last_grant_n;
    logic [CNT_W-1:0]  cnt, cnt_n;

    logic              mem_req_q, mem_req_n;
    logic              mem_we_q, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [BE_W-1:0]   mem_be_q, mem_be_n;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;
    logic              if_ready_q, if_ready_n;
    logic              d_ready_q, d_ready_n;
    logic              d_err_q, d_err_n;
    logic              busy_q, busy_n;

    logic [BE_W-1:0]   d_be_c;
    logic [31:0]       d_wdata_c;
    logic              d_misalign_c;
    logic              grant_d_c;
    logic              grant_i_c;

    mem_lane_align u_lane_align (
        .d_byte     (bus.d_byte),
        .addr       (bus.d_addr[1:0]),
        .d_wdata    (bus.d_wdata),
        .be_c       (d_be_c),
        .wdata_c    (d_wdata_c),
        .misalign_c (d_misalign_c)
    );

    // Data wins a tie unless it was the last one served.
    assign grant_d_c = bus.d_req && (!bus.if_req || (last_grant == GNT_I));
    assign grant_i_c = bus.if_req && !grant_d_c;

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        cnt_n        = (cnt != '0) ? cnt - CNT_W'(1) : '0;
        mem_req_n    = 1'b0;
        mem_we_n     = mem_we_q;
        mem_addr_n   = mem_addr_q;
        mem_be_n     = mem_be_q;
        mem_wdata_n  = mem_wdata_q;
        if_ready_n   = 1'b0;
        d_ready_n    = 1'b0;
        d_err_n      = 1'b0;

        case (state)
            IDLE: begin
                if (grant_d_c) begin
                    last_grant_n = GNT_D;
                    if (d_misalign_c) begin
                        state_n   = ERR_D;
                        d_ready_n = 1'b1;
                        d_err_n   = 1'b1;
                    end else begin
                        state_n     = ACC_D;
                        mem_req_n   = 1'b1;
                        mem_we_n    = bus.d_we;
                        mem_addr_n  = bus.d_addr & WORD_MASK;
                        mem_be_n    = d_be_c;
                        mem_wdata_n = DATA_W'(d_wdata_c);
                        cnt_n       = CNT_W'(MEM_LAT);
                    end
                end else if (grant_i_c) begin
                    last_grant_n = GNT_I;
                    state_n      = ACC_I;
                    mem_req_n    = 1'b1;
                    mem_we_n     = 1'b0;
                    mem_addr_n   = bus.if_addr & WORD_MASK;
                    mem_be_n     = 4'b1111;
                    mem_wdata_n  = '0;
                    cnt_n        = CNT_W'(MEM_LAT);
                end
            end
            ACC_I, ACC_D: begin
                // Ready is registered one cycle ahead so it lands when the count hits zero.
                if (cnt == CNT_W'(1)) begin
                    if_ready_n = (state == ACC_I);
                    d_ready_n  = (state == ACC_D);
                end
                if (cnt == '0) begin
                    state_n     = IDLE;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = '0;
                    mem_be_n    = '0;
                    mem_wdata_n = '0;
                end
            end
            ERR_D: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= GNT_I;
            cnt         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            d_err_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_n;
            last_grant  <= last_grant_n;
            cnt         <= cnt_n;
            mem_req_q   <= mem_req_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_be_q    <= mem_be_n;
            mem_wdata_q <= mem_wdata_n;
            if_ready_q  <= if_ready_n;
            d_ready_q   <= d_ready_n;
            d_err_q     <= d_err_n;
            busy_q      <= busy_n;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_err     = d_err_q;
    assign bus.busy      = busy_q;

    // Read data is a pass-through gated by the ready pulse; error completions return zero.
    assign bus.if_rdata = if_ready_q ? bus.mem_rdata : '0;
    assign bus.d_rdata  = (d_ready_q && !d_err_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with MEM_LAT = 2; cycle 0 is the first
// cycle a request is presented to an idle arbiter.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.MEM_LAT(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_byte    = 2'b00;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    function automatic logic [136:0] all_outputs();
        return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                bus.if_ready, bus.if_rdata, bus.d_ready, bus.d_err, bus.d_rdata};
    endfunction

    task automatic test_reset();
        do_reset();
        bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if (all_outputs() !== '0) begin
            $display("FAIL reset_outputs got=%h exp=0", all_outputs());
            n_fails++;
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            $display("FAIL reset_busy got=%b exp=0", bus.busy);
            n_fails++;
        end
        next_cycle();
    endtask

    task automatic test_fetch();
        logic [31:0] addrs [2];
        addrs = '{32'h0000_0104, 32'h0000_0107};
        do_reset();
        bus.mem_rdata = 32'h0050_0093;
        for (int v = 0; v < 2; v++) begin
            for (int cyc = 0; cyc < 6; cyc++) begin
                bus.if_req  = (cyc <= 3);
                bus.if_addr = addrs[v];
                @(negedge clk);
                n_checks++;
                if (bus.mem_req !== (cyc == 1)) begin
                    $display("FAIL fetch_mem_req v=%0d cyc=%0d got=%b exp=%b", v, cyc, bus.mem_req, cyc == 1);
                    n_fails++;
                end
                n_checks++;
                if (bus.if_ready !== (cyc == 3)) begin
                    $display("FAIL fetch_if_ready v=%0d cyc=%0d got=%b exp=%b", v, cyc, bus.if_ready, cyc == 3);
                    n_fails++;
                end
                n_checks++;
                if (bus.if_rdata !== ((cyc == 3) ? 32'h0050_0093 : 32'h0)) begin
                    $display("FAIL fetch_if_rdata v=%0d cyc=%0d got=%h", v, cyc, bus.if_rdata);
                    n_fails++;
                end
                n_checks++;
                if (bus.busy !== (cyc >= 1 && cyc <= 3)) begin
                    $display("FAIL fetch_busy v=%0d cyc=%0d got=%b", v, cyc, bus.busy);
                    n_fails++;
                end
                if (cyc >= 1 && cyc <= 3) begin
                    n_checks++;
                    if ({bus.mem_addr, bus.mem_be, bus.mem_we} !== {32'h0000_0104, 4'b1111, 1'b0}) begin
                        $display("FAIL fetch_bus v=%0d cyc=%0d got addr=%h be=%b we=%b exp addr=00000104 be=1111 we=0",
                                 v, cyc, bus.mem_addr, bus.mem_be, bus.mem_we);
                        n_fails++;
                    end
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.d_we      = 1'b1;
        bus.d_addr    = 32'h0000_2000;
        bus.d_wdata   = 32'hDEAD_BEEF;
        bus.d_byte    = 2'b10;
        bus.if_addr   = 32'h0000_0100;
        bus.mem_rdata = 32'h0000_0013;
        for (int cyc = 0; cyc < 9; cyc++) begin
            bus.d_req  = (cyc <= 3);
            bus.if_req = (cyc <= 7);
            @(negedge clk);
            n_checks++;
            if (bus.mem_req !== (cyc == 1 || cyc == 5)) begin
                $display("FAIL simul_mem_req cyc=%0d got=%b", cyc, bus.mem_req);
                n_fails++;
            end
            n_checks++;
            if ({bus.d_ready, bus.if_ready} !== {cyc == 3, cyc == 7}) begin
                $display("FAIL simul_ready cyc=%0d got d=%b i=%b", cyc, bus.d_ready, bus.if_ready);
                n_fails++;
            end
            if (cyc == 1) begin
                n_checks++;
                if ({bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr} !==
                    {1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_2000}) begin
                    $display("FAIL simul_d_bus got we=%b be=%b wdata=%h addr=%h exp we=1 be=1111 wdata=deadbeef addr=00002000",
                             bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr);
                    n_fails++;
                end
            end
            if (cyc == 5) begin
                n_checks++;
                if ({bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b0, 4'b1111, 32'h0000_0100}) begin
                    $display("FAIL simul_i_bus got we=%b be=%b addr=%h exp we=0 be=1111 addr=00000100",
                             bus.mem_we, bus.mem_be, bus.mem_addr);
                    n_fails++;
                end
            end
            if (cyc == 7) begin
                n_checks++;
                if (bus.if_rdata !== 32'h0000_0013) begin
                    $display("FAIL simul_if_rdata got=%h exp=00000013", bus.if_rdata);
                    n_fails++;
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_byte_store();
        logic [1:0]  sz   [4];
        logic [31:0] addr [4];
        logic [31:0] wd   [4];
        logic [3:0]  e_be [4];
        logic [31:0] e_wd [4];
        logic [31:0] e_ad [4];
        sz   = '{2'b00, 2'b00, 2'b01, 2'b11};
        addr = '{32'h2003, 32'h2001, 32'h2002, 32'h2004};
        wd   = '{32'h0000_00AB, 32'h0000_00C5, 32'h5678_1234, 32'hCAFE_F00D};
        e_be = '{4'b1000, 4'b0010, 4'b1100, 4'b1111};
        e_wd = '{32'hABAB_ABAB, 32'hC5C5_C5C5, 32'h1234_1234, 32'hCAFE_F00D};
        e_ad = '{32'h2000, 32'h2000, 32'h2000, 32'h2004};
        do_reset();
        for (int v = 0; v < 4; v++) begin
            bus.d_we    = 1'b1;
            bus.d_byte  = sz[v];
            bus.d_addr  = addr[v];
            bus.d_wdata = wd[v];
            for (int cyc = 0; cyc < 5; cyc++) begin
                bus.d_req = (cyc <= 3);
                @(negedge clk);
                if (cyc >= 1 && cyc <= 3) begin
                    n_checks++;
                    if ({bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.mem_we} !== {e_ad[v], e_be[v], e_wd[v], 1'b1}) begin
                        $display("FAIL store_lanes v=%0d cyc=%0d got addr=%h be=%b wdata=%h we=%b exp addr=%h be=%b wdata=%h we=1",
                                 v, cyc, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.mem_we, e_ad[v], e_be[v], e_wd[v]);
                        n_fails++;
                    end
                end
                n_checks++;
                if ({bus.d_ready, bus.d_err} !== {cyc == 3, 1'b0}) begin
                    $display("FAIL store_ready v=%0d cyc=%0d got rdy=%b err=%b", v, cyc, bus.d_ready, bus.d_err);
                    n_fails++;
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz   [3];
        logic [31:0] addr [3];
        sz   = '{2'b10, 2'b01, 2'b11};
        addr = '{32'h2002, 32'h2001, 32'h2003};
        do_reset();
        bus.mem_rdata = 32'hFFFF_FFFF;
        for (int v = 0; v < 3; v++) begin
            bus.d_we   = 1'b0;
            bus.d_byte = sz[v];
            bus.d_addr = addr[v];
            for (int cyc = 0; cyc < 4; cyc++) begin
                bus.d_req = (cyc <= 1);
                @(negedge clk);
                n_checks++;
                if (bus.mem_req !== 1'b0) begin
                    $display("FAIL misalign_mem_req v=%0d cyc=%0d got=%b exp=0", v, cyc, bus.mem_req);
                    n_fails++;
                end
                n_checks++;
                if ({bus.d_ready, bus.d_err, bus.busy} !== {3{cyc == 1}}) begin
                    $display("FAIL misalign_flags v=%0d cyc=%0d got rdy=%b err=%b busy=%b",
                             v, cyc, bus.d_ready, bus.d_err, bus.busy);
                    n_fails++;
                end
                n_checks++;
                if (bus.d_rdata !== 32'h0) begin
                    $display("FAIL misalign_rdata v=%0d cyc=%0d got=%h exp=0", v, cyc, bus.d_rdata);
                    n_fails++;
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.mem_rdata = 32'h1122_3344;
        for (int cyc = 0; cyc < 13; cyc++) begin
            reset       = (cyc == 2);
            bus.if_req  = (cyc <= 2) || (cyc >= 8 && cyc <= 11);
            bus.if_addr = (cyc >= 8) ? 32'h0000_0200 : 32'h0000_0104;
            @(negedge clk);
            if (cyc == 3) begin
                n_checks++;
                if ({all_outputs(), bus.busy} !== '0) begin
                    $display("FAIL rstmid_outputs got=%h busy=%b exp=0", all_outputs(), bus.busy);
                    n_fails++;
                end
            end
            n_checks++;
            if (bus.if_ready !== (cyc == 11)) begin
                $display("FAIL rstmid_if_ready cyc=%0d got=%b", cyc, bus.if_ready);
                n_fails++;
            end
            n_checks++;
            if (bus.mem_req !== (cyc == 1 || cyc == 9)) begin
                $display("FAIL rstmid_mem_req cyc=%0d got=%b", cyc, bus.mem_req);
                n_fails++;
            end
            if (cyc == 9) begin
                n_checks++;
                if (bus.mem_addr !== 32'h0000_0200) begin
                    $display("FAIL rstmid_addr got=%h exp=00000200", bus.mem_addr);
                    n_fails++;
                end
            end
            if (cyc == 11) begin
                n_checks++;
                if (bus.if_rdata !== 32'h1122_3344) begin
                    $display("FAIL rstmid_if_rdata got=%h exp=11223344", bus.if_rdata);
                    n_fails++;
                end
            end
            next_cycle();
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_req;
        logic exp_d;
        do_reset();
        bus.d_we      = 1'b1;
        bus.d_byte    = 2'b10;
        bus.d_addr    = 32'h0000_3000;
        bus.d_wdata   = 32'h0F0F_0F0F;
        bus.if_addr   = 32'h0000_0400;
        bus.mem_rdata = 32'h0000_0055;
        for (int cyc = 0; cyc < 17; cyc++) begin
            bus.d_req  = (cyc <= 15);
            bus.if_req = (cyc <= 15);
            @(negedge clk);
            exp_req = (cyc == 1) || (cyc == 5) || (cyc == 9) || (cyc == 13);
            exp_d   = (cyc == 1) || (cyc == 9);
            n_checks++;
            if (bus.mem_req !== exp_req) begin
                $display("FAIL b2b_mem_req cyc=%0d got=%b exp=%b", cyc, bus.mem_req, exp_req);
                n_fails++;
            end
            n_checks++;
            if ({bus.d_ready, bus.if_ready} !== {cyc == 3 || cyc == 11, cyc == 7 || cyc == 15}) begin
                $display("FAIL b2b_ready cyc=%0d got d=%b i=%b", cyc, bus.d_ready, bus.if_ready);
                n_fails++;
            end
            if (exp_req) begin
                n_checks++;
                if ({bus.mem_we, bus.mem_addr} !== {exp_d, exp_d ? 32'h0000_3000 : 32'h0000_0400}) begin
                    $display("FAIL b2b_grant cyc=%0d got we=%b addr=%h exp we=%b", cyc, bus.mem_we, bus.mem_addr, exp_d);
                    n_fails++;
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch();
        test_simultaneous();
        test_byte_store();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the instruction-fetch port and the data (MEM-stage) port of the 6-stage pipelined core.
- Sequences each access through a small FSM, generates byte enables and aligned write data for sub-word stores, and flags misaligned data accesses.
- Returns per-requester ready pulses that the hazard unit uses to stall.

Parameters:
- MEM_LAT, 2, cycles from the mem_req cycle to the first cycle mem_rdata is valid (>=1).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (fixed at 32; byte-enable width is DATA_W/8).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address (PCF)
- if_rdata  out  DATA_W  fetched instruction word; valid when if_ready
- if_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (ALUResultM)
- d_wdata  in  DATA_W  store data (WriteDataM), right-aligned
- d_byte  in  2  access size: 00 byte, 01 half, 10/11 word (ByteAccessM encoding)
- d_rdata  out  DATA_W  raw memory word; load extension stays in the core
- d_ready  out  1  one-cycle completion pulse for data
- d_err  out  1  misaligned access; pulses together with d_ready
- mem_req  out  1  one-cycle access strobe to memory
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word address; bits [1:0] forced to 0
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_W  lane-replicated write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = I, latency counter 0.
- States: IDLE, ACC_I, ACC_D, ERR_D.
- Requests are sampled only in IDLE.

Grant rules (evaluated in IDLE):
- Only one request pending: grant it.
- Both pending: grant the port opposite to last_grant. After reset D wins first.
- Update last_grant on every grant, including grants that go to ERR_D.

Access timing (grant in IDLE cycle c):
- Address, we, be and wdata are latched at the grant edge.
- Cycle c+1: mem_req = 1 for exactly one cycle.
- mem_addr, mem_we, mem_be and mem_wdata are held stable from c+1 through the ready cycle.
- Counter loads MEM_LAT at c+1 and decrements each cycle.
- Cycle c+1+MEM_LAT: x_ready = 1, x_rdata = mem_rdata (combinational pass-through for that cycle).
- Next state is IDLE. No grant is made in the ready cycle.
- Request-to-ready latency is MEM_LAT+1 cycles. Peak throughput is one access per MEM_LAT+2 cycles.

Fetch accesses:
- mem_we = 0, mem_be = 1111.
- if_addr[1:0] is ignored.

Data byte enables and write data (addr = d_addr[1:0]):
- Byte: be = 0001 << addr; wdata = {4{d_wdata[7:0]}}.
- Half: be = 0011 << {addr[1],0}; wdata = {2{d_wdata[15:0]}}.
- Word: be = 1111; wdata = d_wdata.

Misaligned data accesses:
- A misaligned half (addr[0] = 1) or word (addr != 0) goes to ERR_D with no mem_req.
- Cycle c+1: d_ready = 1, d_err = 1, d_rdata = 0. Then IDLE.

Other rules:
- busy = (state != IDLE).
- If a requester drops its request mid-access, the access still completes and the ready pulse is still issued.
- Reset at any cycle: next cycle is IDLE with all outputs 0. The pending ready is discarded and never issued. last_grant returns to I.
- x_rdata is 0 whenever x_ready = 0.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACC_I, ACC_D, ERR_D}
  - grant enum {GNT_I, GNT_D}
  - constants BA_BYTE = 2'b00, BA_HALF = 2'b01, BA_WORD = 2'b10
- One combinational sub-module, mem_lane_align: inputs d_byte, addr[1:0] and d_wdata; outputs be, replicated wdata and misalign.

Test Plan (MEM_LAT = 2):
1. Fetch only: if_req = 1, if_addr = 0x104 at cycle 0 -> cycle 1: mem_req = 1, mem_addr = 0x104, mem_be = 1111, mem_we = 0. With mem_rdata = 0x00500093 at cycle 3 -> if_ready = 1 and if_rdata = 0x00500093 in cycle 3 only.
2. Simultaneous after reset: d_req store word 0xDEADBEEF to 0x2000, plus if_req 0x100 -> D is served first (mem_req at cycle 1, mem_we = 1, be = 1111, d_ready at cycle 3). Then I: mem_req at cycle 5, if_ready at cycle 7.
3. Byte store: d_byte = 00, d_addr = 0x2003, d_wdata = 0x000000AB -> mem_be = 1000, mem_wdata = 0xABABABAB, mem_addr = 0x2000.
4. Misaligned word load: d_addr = 0x2002 -> d_ready = 1 and d_err = 1 in cycle 1, mem_req never asserted, busy = 1 in cycle 1 only.
5. Reset mid-access: fetch granted at cycle 0, reset high in cycle 2 -> cycle 3: all outputs 0, no if_ready ever issued; a new if_req is granted normally afterwards.
6. Both requests held high continuously for 4 accesses -> grant order D, I, D, I, with mem_req at cycles 1, 5, 9, 13.
